// File: rtl/y86_regfile_sb.sv
// y86_regfile_sb: register file plus per-register pending-write scoreboard for the pipelined
// Y86 core.
//
// Ports:
//   clk, reset_n               clock and asynchronous active-low reset
//   wr_e_* / wr_m_*            writeback ports (E and M stage); M wins on a same-register clash
//   rd_a_* / rd_b_*            combinational decode read ports: data plus pending-write flag
//   iss_valid, iss_dst_e/m     instruction issue from decode, with its two destinations
//   iss_ready                  scoreboard can accept the issued destinations
//   flush                      drops all pending counts (misprediction)
//
// Address all-ones is RNONE: never stored, reads as 0 and not busy.
//
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports
// and to discount same-cycle writebacks from the busy flags.

`timescale 1ns/1ps

module y86_regfile_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_e_en,
    input  logic [ADDR_W-1:0] wr_e_addr,
    input  logic [DATA_W-1:0] wr_e_data,
    input  logic              wr_m_en,
    input  logic [ADDR_W-1:0] wr_m_addr,
    input  logic [DATA_W-1:0] wr_m_data,
    input  logic [ADDR_W-1:0] rd_a_addr,
    output logic [DATA_W-1:0] rd_a_data,
    output logic              rd_a_busy,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic [DATA_W-1:0] rd_b_data,
    output logic              rd_b_busy,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dst_e,
    input  logic [ADDR_W-1:0] iss_dst_m,
    output logic              iss_ready,
    input  logic              flush
);

    localparam int unsigned       NREG    = (2 ** ADDR_W) - 1;
    localparam logic [ADDR_W-1:0] RNONE   = '1;
    // Counter arithmetic runs two bits wider so cnt + 2 never wraps before the compare.
    localparam logic [CNT_W+1:0]  CNT_MAX = (CNT_W + 2)'((2 ** CNT_W) - 1);

    logic [DATA_W-1:0] regQ [NREG];
    logic [DATA_W-1:0] regD [NREG];
    logic [CNT_W-1:0]  cntQ [NREG];
    logic [CNT_W-1:0]  cntD [NREG];
    logic [1:0]        incRaw [NREG];  // destinations hitting each register, ignoring valid
    logic [1:0]        decCnt [NREG];  // enabled writebacks hitting each register
    logic              issAccept;

    // Per-register hit counts and the conservative ready check (same-cycle writes ignored).
    always_comb begin
        iss_ready = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            incRaw[i] = {1'b0, iss_dst_e == ADDR_W'(i)} + {1'b0, iss_dst_m == ADDR_W'(i)};
            decCnt[i] = {1'b0, wr_e_en && (wr_e_addr == ADDR_W'(i))}
                      + {1'b0, wr_m_en && (wr_m_addr == ADDR_W'(i))};
            if (({2'b00, cntQ[i]} + {CNT_W'(0), incRaw[i]}) > CNT_MAX) begin
                iss_ready = 1'b0;
            end
        end
    end

    assign issAccept = iss_valid && iss_ready && !flush;

    // Net counter update: increments and decrements applied together, clamped at zero.
    // Accepted issues guarantee cnt + inc <= max, so the truncation below never loses bits.
    always_comb begin
        logic [1:0]       inc;
        logic [CNT_W+1:0] tot;
        logic [CNT_W+1:0] decW;
        inc  = 2'b00;
        tot  = '0;
        decW = '0;
        for (int i = 0; i < NREG; i++) begin
            inc  = issAccept ? incRaw[i] : 2'b00;
            tot  = {2'b00, cntQ[i]} + {CNT_W'(0), inc};
            decW = {CNT_W'(0), decCnt[i]};
            if (flush) begin
                cntD[i] = '0;
            end else if (tot > decW) begin
                cntD[i] = CNT_W'(tot - decW);
            end else begin
                cntD[i] = '0;
            end
        end
    end

    // Data writes: M is applied after E so it wins a same-register clash.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regD[i] = regQ[i];
            if (wr_e_en && (wr_e_addr == ADDR_W'(i))) begin
                regD[i] = wr_e_data;
            end
            if (wr_m_en && (wr_m_addr == ADDR_W'(i))) begin
                regD[i] = wr_m_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regQ[i] <= '0;
                cntQ[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regQ[i] <= regD[i];
                cntQ[i] <= cntD[i];
            end
        end
    end

    function automatic logic [DATA_W-1:0] readData(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (addr != RNONE) begin
            val = regQ[addr];
`ifdef REGFILE_BYPASS_EN
            // Gated by reset_n so the read ports stay at zero while reset is held.
            if (reset_n && wr_e_en && (wr_e_addr == addr)) begin
                val = wr_e_data;
            end
            if (reset_n && wr_m_en && (wr_m_addr == addr)) begin
                val = wr_m_data;
            end
`endif
        end
        return val;
    endfunction

    function automatic logic readBusy(input logic [ADDR_W-1:0] addr);
        logic busy;
        busy = 1'b0;
        if (addr != RNONE) begin
`ifdef REGFILE_BYPASS_EN
            busy = {2'b00, cntQ[addr]} > {CNT_W'(0), decCnt[addr]};
`else
            busy = cntQ[addr] != '0;
`endif
        end
        return busy;
    endfunction

    always_comb begin
        rd_a_data = readData(rd_a_addr);
        rd_a_busy = readBusy(rd_a_addr);
        rd_b_data = readData(rd_b_addr);
        rd_b_busy = readBusy(rd_b_addr);
    end

endmodule

// File: tb/tb_y86_regfile_sb.sv
`timescale 1ns/1ps

module tb_y86_regfile_sb;

    localparam int RNONE = 15;
    localparam int NREG  = 15;
    localparam int CMAX  = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_e_en, wr_m_en, iss_valid, flush;
    logic [3:0]  wr_e_addr, wr_m_addr, rd_a_addr, rd_b_addr, iss_dst_e, iss_dst_m;
    logic [31:0] wr_e_data, wr_m_data;
    logic [31:0] rd_a_data, rd_b_data;
    logic        rd_a_busy, rd_b_busy, iss_ready;

    int checks = 0;
    int errors = 0;

    // Reference state: architectural values and outstanding-write counts per register.
    logic [31:0] mRegs [NREG];
    int          mCnt  [NREG];

    always #5 clk = ~clk;

    y86_regfile_sb dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_e_en   (wr_e_en),
        .wr_e_addr (wr_e_addr),
        .wr_e_data (wr_e_data),
        .wr_m_en   (wr_m_en),
        .wr_m_addr (wr_m_addr),
        .wr_m_data (wr_m_data),
        .rd_a_addr (rd_a_addr),
        .rd_a_data (rd_a_data),
        .rd_a_busy (rd_a_busy),
        .rd_b_addr (rd_b_addr),
        .rd_b_data (rd_b_data),
        .rd_b_busy (rd_b_busy),
        .iss_valid (iss_valid),
        .iss_dst_e (iss_dst_e),
        .iss_dst_m (iss_dst_m),
        .iss_ready (iss_ready),
        .flush     (flush)
    );

    function automatic logic [31:0] expData(input int a);
        logic [31:0] v;
        if (a == RNONE) return 32'h0;
        v = mRegs[a];
`ifdef REGFILE_BYPASS_EN
        if (reset_n && wr_e_en && int'(wr_e_addr) == a) v = wr_e_data;
        if (reset_n && wr_m_en && int'(wr_m_addr) == a) v = wr_m_data;
`endif
        return v;
    endfunction

    function automatic logic expBusy(input int a);
        int c;
        if (a == RNONE) return 1'b0;
        c = mCnt[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_e_en && int'(wr_e_addr) == a) c--;
        if (wr_m_en && int'(wr_m_addr) == a) c--;
`endif
        return c > 0;
    endfunction

    function automatic logic expReady();
        int de, dm;
        de = int'(iss_dst_e);
        dm = int'(iss_dst_m);
        if (de != RNONE && mCnt[de] + ((de == dm) ? 2 : 1) > CMAX) return 1'b0;
        if (dm != RNONE && mCnt[dm] + ((de == dm) ? 2 : 1) > CMAX) return 1'b0;
        return 1'b1;
    endfunction

    task automatic modelClear();
        for (int i = 0; i < NREG; i++) begin
            mRegs[i] = 32'h0;
            mCnt[i]  = 0;
        end
    endtask

    // Applies one clock edge's worth of the register-file rules to the reference state.
    task automatic modelStep();
        logic acc;
        int   inc, dec, n;
        if (!reset_n) begin
            modelClear();
            return;
        end
        acc = iss_valid && !flush && expReady();
        for (int i = 0; i < NREG; i++) begin
            inc = acc ? ((int'(iss_dst_e) == i ? 1 : 0) + (int'(iss_dst_m) == i ? 1 : 0)) : 0;
            dec = (wr_e_en && int'(wr_e_addr) == i ? 1 : 0) + (wr_m_en && int'(wr_m_addr) == i ? 1 : 0);
            n = mCnt[i] + inc - dec;
            mCnt[i] = flush ? 0 : ((n < 0) ? 0 : n);
        end
        if (wr_e_en && int'(wr_e_addr) != RNONE) mRegs[wr_e_addr] = wr_e_data;
        if (wr_m_en && int'(wr_m_addr) != RNONE) mRegs[wr_m_addr] = wr_m_data;
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic idle();
        wr_e_en = 1'b0; wr_e_addr = 4'hF; wr_e_data = 32'h0;
        wr_m_en = 1'b0; wr_m_addr = 4'hF; wr_m_data = 32'h0;
        iss_valid = 1'b0; iss_dst_e = 4'hF; iss_dst_m = 4'hF;
        flush = 1'b0;
        rd_a_addr = 4'hF; rd_b_addr = 4'hF;
    endtask

    function automatic logic [3:0] pickAddr();
        int r;
        r = $urandom_range(0, 5);
        return (r == 5) ? 4'hF : 4'(r);
    endfunction

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        modelClear();
        #2;
        for (int a = 0; a < 16; a++) begin
            rd_a_addr = 4'(a);
            rd_b_addr = 4'(15 - a);
            #1;
            checks++;
            if (rd_a_data !== 32'h0 || rd_a_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_read_a addr=%0d got data=%h busy=%b want 0/0", a, rd_a_data,
                         rd_a_busy);
            end
            checks++;
            if (rd_b_data !== 32'h0 || rd_b_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_read_b addr=%0d got data=%h busy=%b want 0/0", 15 - a,
                         rd_b_data, rd_b_busy);
            end
        end
        checks++;
        if (iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", iss_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_write_priority();
        idle();
        wr_e_en = 1'b1; wr_e_addr = 4'd3; wr_e_data = 32'h11;
        wr_m_en = 1'b1; wr_m_addr = 4'd3; wr_m_data = 32'h22;
        rd_a_addr = 4'd3;
        @(negedge clk);
        checks++;
        if (rd_a_data !== expData(3)) begin
            errors++;
            $display("FAIL prio_same_cycle got %h want %h", rd_a_data, expData(3));
        end
        tick();
        idle();
        rd_a_addr = 4'd3;
        @(negedge clk);
        checks++;
        if (rd_a_data !== 32'h22) begin
            errors++;
            $display("FAIL prio_m_wins got %h want 00000022", rd_a_data);
        end
        tick();
    endtask

    task automatic test_counter_sat();
        for (int k = 0; k < 3; k++) begin
            idle();
            iss_valid = 1'b1; iss_dst_e = 4'd2;
            @(negedge clk);
            checks++;
            if (iss_ready !== 1'b1) begin
                errors++;
                $display("FAIL sat_issue%0d ready got %b want 1", k, iss_ready);
            end
            tick();
        end
        idle();
        iss_valid = 1'b1; iss_dst_e = 4'd2; rd_a_addr = 4'd2;
        @(negedge clk);
        checks++;
        if (rd_a_busy !== 1'b1 || iss_ready !== 1'b0) begin
            errors++;
            $display("FAIL sat_full got busy=%b ready=%b want busy=1 ready=0", rd_a_busy, iss_ready);
        end
        tick();
        idle();
        wr_e_en = 1'b1; wr_e_addr = 4'd2; wr_e_data = $urandom;
        tick();
        idle();
        iss_dst_e = 4'd2;
        @(negedge clk);
        checks++;
        if (iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL sat_after_write ready got %b want 1", iss_ready);
        end
        for (int k = 0; k < 2; k++) begin
            idle();
            wr_e_en = 1'b1; wr_e_addr = 4'd2; wr_e_data = $urandom;
            tick();
        end
        idle();
        rd_a_addr = 4'd2;
        @(negedge clk);
        checks++;
        if (rd_a_busy !== 1'b0 || rd_a_data !== mRegs[2]) begin
            errors++;
            $display("FAIL sat_drained got busy=%b data=%h want busy=0 data=%h", rd_a_busy,
                     rd_a_data, mRegs[2]);
        end
        tick();
    endtask

    task automatic test_issue_with_writeback();
        idle();
        iss_valid = 1'b1; iss_dst_e = 4'd5;
        tick();
        idle();
        iss_valid = 1'b1; iss_dst_e = 4'd5;
        wr_e_en = 1'b1; wr_e_addr = 4'd5; wr_e_data = 32'h5A5A;
        rd_a_addr = 4'd5;
        @(negedge clk);
        checks++;
        if (rd_a_busy !== expBusy(5)) begin
            errors++;
            $display("FAIL iwb_same_cycle busy got %b want %b", rd_a_busy, expBusy(5));
        end
        tick();
        idle();
        rd_a_addr = 4'd5;
        @(negedge clk);
        checks++;
        if (rd_a_busy !== 1'b1 || rd_a_data !== 32'h5A5A) begin
            errors++;
            $display("FAIL iwb_net got busy=%b data=%h want busy=1 data=00005a5a", rd_a_busy,
                     rd_a_data);
        end
        tick();
    endtask

    task automatic test_flush();
        idle();
        iss_valid = 1'b1; iss_dst_e = 4'd6; iss_dst_m = 4'd1;
        tick();
        idle();
        flush = 1'b1;
        iss_valid = 1'b1; iss_dst_e = 4'd6;
        wr_e_en = 1'b1; wr_e_addr = 4'd7; wr_e_data = 32'hAB;
        tick();
        idle();
        for (int a = 0; a < 16; a++) begin
            rd_a_addr = 4'(a);
            #1;
            checks++;
            if (rd_a_busy !== 1'b0) begin
                errors++;
                $display("FAIL flush_busy addr=%0d got %b want 0", a, rd_a_busy);
            end
        end
        rd_b_addr = 4'd7;
        #1;
        checks++;
        if (rd_b_data !== 32'hAB) begin
            errors++;
            $display("FAIL flush_write r7 got %h want 000000ab", rd_b_data);
        end
        tick();
    endtask

    task automatic test_rnone();
        idle();
        wr_e_en = 1'b1; wr_e_addr = 4'hF; wr_e_data = 32'hFF;
        wr_m_en = 1'b1; wr_m_addr = 4'hF; wr_m_data = 32'hFF;
        rd_a_addr = 4'hF;
        @(negedge clk);
        checks++;
        if (rd_a_data !== 32'h0 || rd_a_busy !== 1'b0) begin
            errors++;
            $display("FAIL rnone_same_cycle got %h/%b want 0/0", rd_a_data, rd_a_busy);
        end
        tick();
        idle();
        for (int a = 0; a < 16; a++) begin
            rd_a_addr = 4'(a);
            #1;
            checks++;
            if (rd_a_data !== expData(a)) begin
                errors++;
                $display("FAIL rnone_regs addr=%0d got %h want %h", a, rd_a_data, expData(a));
            end
        end
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            wr_e_en = 1'($urandom); wr_e_addr = pickAddr(); wr_e_data = $urandom;
            wr_m_en = 1'($urandom); wr_m_addr = pickAddr(); wr_m_data = $urandom;
            iss_valid = 1'($urandom); iss_dst_e = pickAddr(); iss_dst_m = pickAddr();
            flush = ($urandom_range(0, 19) == 0);
            rd_a_addr = pickAddr();
            rd_b_addr = 4'($urandom_range(0, 15));
            @(negedge clk);
            checks++;
            if (rd_a_data !== expData(int'(rd_a_addr)) || rd_a_busy !== expBusy(int'(rd_a_addr))) begin
                errors++;
                $display("FAIL rand_a cyc=%0d addr=%0d got %h/%b want %h/%b", k, rd_a_addr,
                         rd_a_data, rd_a_busy, expData(int'(rd_a_addr)), expBusy(int'(rd_a_addr)));
            end
            checks++;
            if (rd_b_data !== expData(int'(rd_b_addr)) || rd_b_busy !== expBusy(int'(rd_b_addr))) begin
                errors++;
                $display("FAIL rand_b cyc=%0d addr=%0d got %h/%b want %h/%b", k, rd_b_addr,
                         rd_b_data, rd_b_busy, expData(int'(rd_b_addr)), expBusy(int'(rd_b_addr)));
            end
            checks++;
            if (iss_ready !== expReady()) begin
                errors++;
                $display("FAIL rand_ready cyc=%0d dst=%0d/%0d got %b want %b", k, iss_dst_e,
                         iss_dst_m, iss_ready, expReady());
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        idle();
        wr_e_en = 1'b1; wr_e_addr = 4'd4; wr_e_data = 32'h1234;
        iss_valid = 1'b1; iss_dst_e = 4'd4;
        tick();
        idle();
        rd_a_addr = 4'd4;
        #1;
        checks++;
        if (rd_a_data !== 32'h1234 || rd_a_busy !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre got %h/%b want 00001234/1", rd_a_data, rd_a_busy);
        end
        #1;
        reset_n = 1'b0;
        modelClear();
        #1;
        checks++;
        if (rd_a_data !== 32'h0 || rd_a_busy !== 1'b0 || iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL areset_now got %h/%b ready=%b want 0/0 ready=1", rd_a_data, rd_a_busy,
                     iss_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        idle();
        test_reset();
        test_write_priority();
        test_counter_sat();
        test_issue_with_writeback();
        test_flush();
        test_rnone();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/y86_regfile_sb.md
# y86_regfile_sb

Parametrised register file with scoreboard for the pipelined Y86 core. It provides two write ports (E and M writeback), two combinational read ports (decode) and per-register pending-write counters. Decode uses these counters to detect data hazards and stall.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, register address width; 2**ADDR_W entries; address all-ones is RNONE (no register)
- CNT_W, 2, pending-write counter width per register; max outstanding writes = 2**CNT_W-1

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_e_en  in  1  write enable, E port
- wr_e_addr  in  ADDR_W  E destination
- wr_e_data  in  DATA_W  E value
- wr_m_en  in  1  write enable, M port
- wr_m_addr  in  ADDR_W  M destination
- wr_m_data  in  DATA_W  M value
- rd_a_addr  in  ADDR_W  read port A address
- rd_a_data  out  DATA_W  read port A value
- rd_a_busy  out  1  A has a pending write
- rd_b_addr, rd_b_data, rd_b_busy  in/out/out  ADDR_W/DATA_W/1  read port B, same as A
- iss_valid  in  1  decode issues an instruction
- iss_dst_e  in  ADDR_W  E destination of the issued instruction
- iss_dst_m  in  ADDR_W  M destination of the issued instruction
- iss_ready  out  1  scoreboard can accept the issue
- flush  in  1  clears all pending counters (misprediction)

## Operation
- Storage: 2**ADDR_W-1 real registers of DATA_W bits. RNONE is not stored.
- Writes:
  - A write to RNONE, or with enable low, is ignored.
  - If E and M target the same register in one cycle, M wins.
- Reads:
  - Combinational from current state.
  - Reading RNONE gives data 0 and busy 0.
- Counter increment:
  - Issue is accepted when iss_valid & iss_ready & !flush.
  - Each real destination increments its counter by 1.
  - dst_e == dst_m (real) increments that counter by 2.
- Counter decrement:
  - Each enabled write to a real register decrements its counter by 1, saturating at 0. No underflow; writes to a register with counter 0 are legal.
  - Two ports writing the same register decrement it by 2, saturating at 0.
- Simultaneous accepted issue and writeback on the same register: net = increments − decrements, applied in one step.
- iss_ready:
  - Conservative; high iff for every real destination, current count + its increment ≤ 2**CNT_W-1.
  - Same-cycle decrements are ignored.
  - Both destinations RNONE: iss_ready = 1.
- Flush:
  - All counters become 0 next cycle.
  - Issue in the same cycle is dropped.
  - Writes in the same cycle still update data.
- Reset: all registers 0, all counters 0.

## Timing
- Write data visible in storage one cycle after the edge.
- Counter update latency: 1 cycle.
- Output values while reset_n is low and just after reset: rd_a_data/rd_b_data = 0, rd_a_busy/rd_b_busy = 0, iss_ready = 1.
- Reset asserted mid-operation clears storage and counters immediately (asynchronously). It overrides flush, issue and writes.
- No handshake on write ports. The issue handshake completes in the same cycle iss_valid & iss_ready are high.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read whose address matches a same-cycle enabled write returns the write data (M over E).
  - rd_*_busy = (count − same-cycle decrements to that register) > 0.
- Undefined:
  - Reads return stored value only; writes are seen next cycle.
  - rd_*_busy = count > 0.

## Test plan
- Reset, then read all 16 addresses: data 0 and busy 0 everywhere; iss_ready = 1.
- Write E r3=0x11 and M r3=0x22 in the same cycle: next cycle r3 reads 0x22. With BYPASS, the same-cycle read of r3 also returns 0x22.
- Issue dst_e=r2, dst_m=RNONE three times (CNT_W=2):
  - r2 busy; a fourth issue to r2 sees iss_ready = 0.
  - One E write to r2 → iss_ready = 1 next cycle.
  - Three writes total → busy 0.
- Issue r5 with a concurrent E write to r5 (count was 1): count stays 1, busy remains 1.
- Flush with iss_valid to r6 and write r7=0xAB: all counters 0, r6 not busy, r7 = 0xAB.
- Write RNONE with 0xFF, read RNONE: data 0; no register changed.
